// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-interlock constants: FSM encodings, forward-select codes and
// the per-cycle pipeline-register control word.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_DIV_BUSY = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_DIV      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BR       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_EXCP     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // EX forwarding only for non-load producers; a load in EX must stall instead.
  function automatic logic [1:0] fwd_sel(input logic valid, input logic re,
                                         input logic exe_rel, input logic mem_rel,
                                         input logic ex_memtoreg);
    logic [1:0] sel;
    sel = FWD_RF;
    if (valid && re && exe_rel && !ex_memtoreg) sel = FWD_EX;
    else if (valid && re && mem_rel)            sel = FWD_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-detector / pipeline-control bundle between the ID stage and the interlock.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid_i;
  logic             id_re1_i;
  logic             id_re2_i;
  logic             exe_relate1_i;
  logic             exe_relate2_i;
  logic             mem_relate1_i;
  logic             mem_relate2_i;
  logic             ex_memtoreg_i;
  logic             ex_div_start_i;
  logic             br_flush_i;
  logic             excp_flush_i;
  logic             cnt_clr_i;
  logic [1:0]       fwd1_sel_o;
  logic [1:0]       fwd2_sel_o;
  logic             pc_we_o;
  logic             ifid_we_o;
  logic             idex_we_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             exmem_flush_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_valid_i, id_re1_i, id_re2_i, exe_relate1_i, exe_relate2_i,
           mem_relate1_i, mem_relate2_i, ex_memtoreg_i, ex_div_start_i,
           br_flush_i, excp_flush_i, cnt_clr_i,
    input  fwd1_sel_o, fwd2_sel_o, pc_we_o, ifid_we_o, idex_we_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, state_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_re1_i, id_re2_i, exe_relate1_i, exe_relate2_i,
           mem_relate1_i, mem_relate2_i, ex_memtoreg_i, ex_div_start_i,
           br_flush_i, excp_flush_i, cnt_clr_i,
    output fwd1_sel_o, fwd2_sel_o, pc_we_o, ifid_we_o, idex_we_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module hazard_stall_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] q_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && ~&cnt_q)     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: forwarding selects, load-use / divide stalls, branch and
// exception flushes, plus a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int unsigned DIV_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             load_use;
  ctrl_t            ctrl;
  logic [1:0]       fwd1, fwd2;

  assign load_use = bus.id_valid_i & bus.ex_memtoreg_i &
                    ((bus.id_re1_i & bus.exe_relate1_i) | (bus.id_re2_i & bus.exe_relate2_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Divide start cycle plus DIV_CYCLES-1 busy cycles; last busy cycle sees count 1.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      ST_DIV_BUSY: begin
        if (bus.excp_flush_i) begin
          state_d   = ST_FLUSH;
          div_cnt_d = '0;
        end else if (div_cnt_q <= DIV_W'(1)) begin
          state_d   = ST_RUN;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default: begin
        state_d = ST_RUN;
        if (bus.excp_flush_i) begin
          state_d   = ST_FLUSH;
          div_cnt_d = '0;
        end else if (bus.br_flush_i) begin
          state_d = ST_RUN;
        end else if (bus.ex_div_start_i) begin
          state_d   = ST_DIV_BUSY;
          div_cnt_d = DIV_W'(DIV_CYCLES - 1);
        end
      end
    endcase
  end

  // Controls are combinational and forced quiet while reset is asserted.
  always_comb begin
    ctrl = CTRL_RUN;
    fwd1 = fwd_sel(bus.id_valid_i, bus.id_re1_i, bus.exe_relate1_i,
                   bus.mem_relate1_i, bus.ex_memtoreg_i);
    fwd2 = fwd_sel(bus.id_valid_i, bus.id_re2_i, bus.exe_relate2_i,
                   bus.mem_relate2_i, bus.ex_memtoreg_i);
    if (rst) begin
      ctrl = CTRL_OFF;
      fwd1 = FWD_RF;
      fwd2 = FWD_RF;
    end else begin
      case (state_q)
        ST_DIV_BUSY: ctrl = bus.excp_flush_i ? CTRL_EXCP : CTRL_DIV;
        ST_FLUSH:    ctrl = CTRL_FLUSH;
        default: begin
          if (bus.excp_flush_i)        ctrl = CTRL_EXCP;
          else if (bus.br_flush_i)     ctrl = CTRL_BR;
          else if (bus.ex_div_start_i) ctrl = CTRL_DIV;
          else if (load_use)           ctrl = CTRL_LOAD_USE;
        end
      endcase
    end
  end

  assign bus.fwd1_sel_o    = fwd1;
  assign bus.fwd2_sel_o    = fwd2;
  assign bus.pc_we_o       = ctrl.pc_we;
  assign bus.ifid_we_o     = ctrl.ifid_we;
  assign bus.idex_we_o     = ctrl.idex_we;
  assign bus.ifid_flush_o  = ctrl.ifid_flush;
  assign bus.idex_flush_o  = ctrl.idex_flush;
  assign bus.exmem_flush_o = ctrl.exmem_flush;
  assign bus.state_o       = state_q;

  hazard_stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~ctrl.pc_we & ~rst),
    .clr_i (bus.cnt_clr_i),
    .q_o   (bus.stall_cnt_o)
  );
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline interlock controller that consumes the per-port EX/MEM relate flags from the ID-stage data-hazard detector and turns them into forwarding selects, stall enables and flush/bubble controls for the 5-stage single-issue core. It also sequences multi-cycle divide stalls and branch/exception flushes, and keeps a saturating stall-cycle counter. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM pipeline-register controls.

## Interface
- DIV_CYCLES, 8, EX occupancy of a divide in cycles (legal ≥ 2)
- CNT_W, 32, stall counter width
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- id_valid_i  in  1  ID holds a valid instruction
- id_re1_i / id_re2_i  in  1  ID instruction reads regfile port 1 / 2
- exe_relate1_i / exe_relate2_i  in  1  port 1 / 2 address matches EX write
- mem_relate1_i / mem_relate2_i  in  1  port 1 / 2 address matches MEM write
- ex_memtoreg_i  in  1  EX instruction is a load
- ex_div_start_i  in  1  divide enters EX this cycle
- br_flush_i  in  1  taken branch/jump resolved in EX
- excp_flush_i  in  1  exception/ertn committed in MEM
- cnt_clr_i  in  1  synchronous clear of stall counter
- fwd1_sel_o / fwd2_sel_o  out  2  00 regfile, 01 EX result, 10 MEM result
- pc_we_o, ifid_we_o, idex_we_o  out  1  register write enables
- ifid_flush_o, idex_flush_o, exmem_flush_o  out  1  load bubble into register
- state_o  out  2  FSM state
- stall_cnt_o  out  CNT_W  stall cycles since reset/clear

## Operation
- Forwarding (combinational, per port n): idn&exe_relaten&!ex_memtoreg → 01; else idn&mem_relaten → 10; else 00. EX beats MEM. Gated by id_valid_i.
- load_use = id_valid_i & ex_memtoreg_i & ((id_re1&exe_relate1)|(id_re2&exe_relate2)).
- FSM states RUN=00, DIV_BUSY=01, FLUSH=10; 11 unreachable, decoded as RUN.
- Priority within a cycle: excp_flush > br_flush > div_start > load_use.
- RUN:
  - excp_flush: ifid/idex/exmem_flush=1, pc_we=1 → FLUSH.
  - br_flush: ifid/idex_flush=1, pc_we=1, stay RUN; a coincident load_use/div_start is ignored.
  - div_start: pc/ifid/idex_we=0, exmem_flush=1; div counter ← DIV_CYCLES-1 → DIV_BUSY.
  - load_use: pc_we=ifid_we=0, idex_flush=1, idex_we=1; stay RUN (one bubble; next cycle the load is in MEM and forwarding selects 10).
  - otherwise all we=1, all flush=0.
- DIV_BUSY: pc/ifid/idex_we=0, exmem_flush=1; counter decrements; on counter==0 in this state → RUN with same outputs that cycle. excp_flush aborts immediately (RUN excp behaviour, counter ← 0) → FLUSH. br_flush ignored (EX is the divide).
- FLUSH: ifid_flush=idex_flush=1, pc_we=1 (drains wrong-path fetch) → RUN unconditionally; all other inputs ignored.
- stall_cnt: +1 on each cycle with pc_we_o=0 and rst low; saturates at all-ones; cnt_clr_i wins over increment (→0).

## Timing
- Forward selects, we, flush: combinational from state and inputs, same cycle.
- Divide: EX held exactly DIV_CYCLES cycles including the div_start cycle; RUN resumes on cycle DIV_CYCLES+1.
- Load-use: exactly one stall cycle.
- Reset (async): state=RUN, div counter=0, stall_cnt=0; while rst high all outputs 0, fwd selects 00, state_o=00. First cycle after release behaves as RUN.
- Reset mid-divide or mid-flush: state discarded, no residual stall.

## Structure
- State encodings, fwd select codes (00/01/10) go in the shared define header with other pipeline constants.
- Sub-module: sat_counter (CNT_W, inc, clr, async active-high rst) for stall_cnt.
- Div counter width $clog2(DIV_CYCLES).

## Test plan
- ID reads r5 port1, EX writes r5 (non-load), MEM writes r5 → fwd1_sel=01, no stall, all we=1.
- Load in EX writes r7, ID reads r7 on port2 → one cycle pc_we=ifid_we=0, idex_flush=1; next cycle fwd2_sel=10, stall_cnt=1.
- div_start with DIV_CYCLES=8 → pc_we=0 for 8 cycles, state_o=01, then 00; stall_cnt +8.
- excp_flush on 3rd DIV_BUSY cycle → all three flushes that cycle, FLUSH next cycle (ifid/idex_flush=1), RUN after.
- br_flush coincident with load_use → ifid/idex_flush=1, pc_we=1, no stall counted.
- stall_cnt with CNT_W=4 forced 15 stall cycles plus more → holds 15; cnt_clr_i → 0; async rst mid-DIV_BUSY → state_o=00, outputs 0 during rst.
